// File: rtl/mv_avg_filter_v2_0.sv
// mv_avg_filter_v2_0: moving-average (boxcar) filter over the last 2^LOG2_DEPTH
// prescaled samples. It uses a circular delay line and a full-precision running
// sum, so no truncation error builds up between taps.
//
// Optional feature macro: MV_AVG_ROUNDING_EN
//   defined   -> round-half-up average
//   undefined -> floor average (arithmetic shift only)
//
// Ports:
//   clk          clock
//   rst          synchronous active-high reset
//   i_prescaler  sample-tick divider; a tick occurs every i_prescaler+1 cycles
//   i_clear      synchronous flush of the filter state (prescaler unaffected)
//   is_data      signed input sample, taken only on a tick
//   os_data      registered signed average
//   o_valid      one-cycle pulse when os_data updates
//   o_filled     high once DEPTH samples have been taken since reset/clear
module mv_avg_filter_v2_0 #(
    parameter int unsigned DATA_WIDTH      = 14,
    parameter int unsigned LOG2_DEPTH      = 3,
    parameter int unsigned PRESCALER_WIDTH = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic        [PRESCALER_WIDTH-1:0] i_prescaler,
    input  logic                              i_clear,
    input  logic signed [DATA_WIDTH-1:0]      is_data,
    output logic signed [DATA_WIDTH-1:0]      os_data,
    output logic                              o_valid,
    output logic                              o_filled
);

    localparam int unsigned DEPTH  = 1 << LOG2_DEPTH;
    localparam int unsigned SUM_W  = DATA_WIDTH + LOG2_DEPTH;
    localparam int unsigned FILL_W = LOG2_DEPTH + 1;

    typedef enum logic {
        S_FILL = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                       r_state;
    state_t                       w_state_next;
    logic        [PRESCALER_WIDTH-1:0] r_presc_cnt;
    logic        [LOG2_DEPTH-1:0] r_wr_ptr;
    logic        [FILL_W-1:0]     r_fill_cnt;
    logic        [FILL_W-1:0]     w_fill_cnt_next;
    logic                         w_filled_next;
    logic signed [SUM_W-1:0]      r_sum;
    logic signed [SUM_W-1:0]      w_sum_next;
    logic signed [SUM_W-1:0]      w_in_ext;
    logic signed [SUM_W-1:0]      w_old_ext;
    logic signed [DATA_WIDTH-1:0] w_oldest;
    logic signed [DATA_WIDTH-1:0] w_avg;
    logic                         w_tick;
    logic                         w_take;
    logic signed [DATA_WIDTH-1:0] r_buf [DEPTH];

    // Sample tick: fires when the counter has reached (or passed) the divider.
    assign w_tick = (r_presc_cnt >= i_prescaler);
    // A clear in the same cycle as a tick discards the sample.
    assign w_take = w_tick & ~i_clear;

    // Prescaler counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc_cnt <= '0;
        end else if (w_tick) begin
            r_presc_cnt <= '0;
        end else begin
            r_presc_cnt <= r_presc_cnt + PRESCALER_WIDTH'(1);
        end
    end

    // During FILL, stale buffer contents are masked out of the running sum.
    assign w_oldest   = (r_state == S_RUN) ? r_buf[r_wr_ptr] : '0;
    assign w_in_ext   = SUM_W'(is_data);
    assign w_old_ext  = SUM_W'(w_oldest);
    assign w_sum_next = r_sum + w_in_ext - w_old_ext;

`ifdef MV_AVG_ROUNDING_EN
    localparam logic signed [SUM_W:0] RND_HALF = (SUM_W+1)'(1) << (LOG2_DEPTH - 1);
    logic signed [SUM_W:0] w_sum_rnd;
    assign w_sum_rnd = (SUM_W+1)'(w_sum_next) + RND_HALF;
    assign w_avg     = DATA_WIDTH'(w_sum_rnd >>> LOG2_DEPTH);
`else
    assign w_avg     = DATA_WIDTH'(w_sum_next >>> LOG2_DEPTH);
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state, fill count and filled flag
    always_comb begin
        w_state_next    = r_state;
        w_fill_cnt_next = r_fill_cnt;
        w_filled_next   = (r_state == S_RUN);
        case (r_state)
            S_FILL: begin
                if (w_take) begin
                    w_fill_cnt_next = r_fill_cnt + FILL_W'(1);
                    if (w_fill_cnt_next == FILL_W'(DEPTH)) begin
                        w_state_next  = S_RUN;
                        w_filled_next = 1'b1;
                    end
                end
            end
            S_RUN: begin
                w_state_next = S_RUN;
            end
            default: begin
                w_state_next = S_FILL;
            end
        endcase
        if (i_clear) begin
            w_state_next    = S_FILL;
            w_fill_cnt_next = '0;
            w_filled_next   = 1'b0;
        end
    end

    // Fill count and filled flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fill_cnt <= '0;
            o_filled   <= 1'b0;
        end else begin
            r_fill_cnt <= w_fill_cnt_next;
            o_filled   <= w_filled_next;
        end
    end

    // Running sum, write pointer and registered outputs
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_sum    <= '0;
            r_wr_ptr <= '0;
            os_data  <= '0;
            o_valid  <= 1'b0;
        end else begin
            o_valid <= w_tick;
            if (w_tick) begin
                r_sum    <= w_sum_next;
                r_wr_ptr <= r_wr_ptr + LOG2_DEPTH'(1);
                os_data  <= w_avg;
            end
        end
    end

    // Delay line; never reset, since FILL masks its contents
    always_ff @(posedge clk) begin
        if (!rst && w_take) begin
            r_buf[r_wr_ptr] <= is_data;
        end
    end

endmodule

// File: tb/tb_mv_avg_filter_v2_0.sv
module tb_mv_avg_filter_v2_0;

    localparam int W  = 14;
    localparam int D  = 8;
    localparam int PW = 32;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic        [PW-1:0] i_prescaler = '0;
    logic                 i_clear = 1'b0;
    logic signed [W-1:0]  is_data = '0;
    logic signed [W-1:0]  os_data;
    logic                 o_valid;
    logic                 o_filled;

    mv_avg_filter_v2_0 dut (
        .clk         (clk),
        .rst         (rst),
        .i_prescaler (i_prescaler),
        .i_clear     (i_clear),
        .is_data     (is_data),
        .os_data     (os_data),
        .o_valid     (o_valid),
        .o_filled    (o_filled)
    );

    always #5 clk = ~clk;

    typedef struct {
        int data;
        bit filled;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   hist[$];
    int   n_taken  = 0;
    int   m_cnt    = 0;
    int   presc    = 0;
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   chk_zero = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int floor_div(input int s);
        int q;
        q = s / D;
        if ((s % D) != 0 && s < 0) q = q - 1;
        return q;
    endfunction

    // Reference average of the last D samples, zero-padded while filling.
    function automatic int ref_avg();
        int s = 0;
        foreach (hist[i]) s += hist[i];
`ifdef MV_AVG_ROUNDING_EN
        return floor_div(s + D / 2);
`else
        return floor_div(s);
`endif
    endfunction

    task automatic check(input bit ok, input string name, input int act, input int req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
        end
    endtask

    // Drive one cycle of stimulus and predict its effect.
    task automatic drive(input int data, input bit clr, input bit rs);
        bit   tick;
        exp_t e;
        @(negedge clk);
        #1;
        rst         = rs;
        i_clear     = clr;
        is_data     = W'(data);
        i_prescaler = PW'(presc);
        if (rs) begin
            hist.delete();
            n_taken  = 0;
            m_cnt    = 0;
            chk_zero = 1'b1;
        end else begin
            tick = (m_cnt >= presc);
            if (clr) begin
                hist.delete();
                n_taken  = 0;
                chk_zero = 1'b1;
            end else if (tick) begin
                hist.push_back(int'(is_data));
                if (hist.size() > D) void'(hist.pop_front());
                n_taken++;
                e.data   = ref_avg();
                e.filled = (n_taken >= D);
                e.cyc    = cyc + 1;
                sb.push_back(e);
            end
            m_cnt = tick ? 0 : m_cnt + 1;
        end
    endtask

    // Monitor: compares every presented output against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (chk_zero) begin
            check(os_data == 0 && !o_valid && !o_filled, "zero_after_clear_or_reset",
                  int'(os_data) + (o_valid ? 100000 : 0) + (o_filled ? 200000 : 0), 0);
            chk_zero = 1'b0;
        end
        if (o_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check(1'b0, "spurious_valid", 1, 0);
            end else begin
                e = sb.pop_front();
                check(int'(os_data) == e.data, "os_data", int'(os_data), e.data);
                check(o_filled == e.filled, "o_filled", int'(o_filled), int'(e.filled));
                check(cyc == e.cyc, "valid_cycle", cyc, e.cyc);
            end
        end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            check(1'b0, "missing_valid", cyc, e.cyc);
        end
    end

    initial begin
        // Reset
        presc = 0;
        drive(0, 0, 1);
        drive(0, 0, 1);

        // Step response
        for (int i = 0; i < 12; i++) drive(800, 0, 0);

        // Clear coincident with a tick in RUN, then restart
        drive(800, 1, 0);
        for (int i = 0; i < 3; i++) drive(800, 0, 0);

        // Negative sample floor behaviour
        drive(0, 1, 0);
        drive(-1, 0, 0);
        for (int i = 0; i < 11; i++) drive(0, 0, 0);

        // Small positive sample (rounding boundary)
        drive(0, 1, 0);
        drive(4, 0, 0);
        for (int i = 0; i < 9; i++) drive(0, 0, 0);

        // Prescaler = 3 with data changing every cycle
        presc = 3;
        for (int i = 0; i < 48; i++) drive(int'($urandom_range(0, 16383)) - 8192, 0, 0);

        // Full-scale alternation and constant full scale
        presc = 0;
        drive(0, 1, 0);
        for (int i = 0; i < 32; i++) drive((i % 2 == 0) ? 8191 : -8192, 0, 0);
        for (int i = 0; i < 12; i++) drive(8191, 0, 0);
        for (int i = 0; i < 12; i++) drive(-8192, 0, 0);

        // Reset mid-run, then the step response again
        drive(800, 0, 1);
        for (int i = 0; i < 12; i++) drive(800, 0, 0);

        // Randomised mix of prescaler values, data and clears
        for (int blk = 0; blk < 12; blk++) begin
            presc = int'($urandom_range(0, 4));
            for (int i = 0; i < 25; i++)
                drive(int'($urandom_range(0, 16383)) - 8192, ($urandom_range(0, 30) == 0), 0);
        end

        // Drain: stop ticking and confirm nothing is still outstanding
        presc = 100000;
        for (int i = 0; i < 4; i++) drive(0, 0, 0);
        @(negedge clk);
        #1;
        check(sb.size() == 0, "scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
